sdhci_dat_tx: RTL and testbench

SDHCI_DAT_TX -- requirements
Module: sdhci_dat_tx

---
 rtl/sdhci_pkg.sv | 23 ++
 rtl/sdhci_crc16.sv | 30 +++
 rtl/sdhci_dat_tx.sv | 251 +++++++++++++++++++++++++
 tb/tb_sdhci_dat_tx.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdhci_pkg.sv
// Shared types and constants for the SD host DAT-line transmit path.
package sdhci_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        CRC,
        END
    } tx_state_e;

    // CRC16-CCITT generator x^16 + x^12 + x^5 + 1 (x^16 term implied).
    localparam logic [15:0] CRC16_POLY   = 16'h1021;
    localparam int          MAX_BLK_SIZE = 2048;

    // Byte 0 goes out first and each byte MSB first, so reversing the byte
    // order lets the transmitter always shift from bit 31 downwards.
    function automatic logic [31:0] byte_reorder(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/sdhci_crc16.sv
// Serial CRC16 for one DAT line: one data bit per enable, synchronous clear.
module sdhci_crc16
    import sdhci_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;
    logic        feedback;

    assign feedback = bit_i ^ crc_q[15];
    assign crc_o    = crc_q;

    // Shift the register once per enabled data bit; clear wins over enable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q <= '0;
        end else if (clr_i) begin
            crc_q <= '0;
        end else if (en_i) begin
            crc_q <= {crc_q[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/sdhci_dat_tx.sv
// SD DAT-line block transmitter: start bit, data from the buffer FIFO,
// per-line CRC16, end bit. Requests SD-clock gating when data is starved.
module sdhci_dat_tx
    import sdhci_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int BlkSizeWidth = 12
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    sd_clk_en_i,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic                    bus_4bit_i,
    input  logic [BlkSizeWidth-1:0] block_size_i,
    input  logic                    fifo_empty_i,
    input  logic [DataWidth-1:0]    fifo_front_data_i,
    output logic                    fifo_pop_o,
    output logic [3:0]              dat_o,
    output logic [3:0]              dat_oe_o,
    output logic                    clk_stop_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam logic [BlkSizeWidth:0] WordBytes = (BlkSizeWidth+1)'(4);

    tx_state_e             state_q, state_d;
    logic                  bus4_q, bus4_d;
    logic [BlkSizeWidth:0] byte_cnt_q, byte_cnt_d;   // bytes not yet fetched
    logic [31:0]           shift_q, shift_d;
    logic [5:0]            bits_left_q, bits_left_d; // bit-times left in word
    logic [3:0]            crc_idx_q, crc_idx_d;     // CRC bit on the line
    logic [3:0]            dat_q, dat_d;
    logic [3:0]            oe_q, oe_d;
    logic                  stall_q, stall_d;
    logic [1:0]            pop_wait_q, pop_wait_d;   // front-word settle time
    logic                  done_q, done_d;

    logic        pop;
    logic        crc_clr;
    logic        crc_en;
    logic        word_avail;
    logic [3:0]  active;
    logic [5:0]  word_bits;
    logic [31:0] new_word;
    logic [31:0] src;
    logic [3:0]  src_bits;
    logic [3:0]  crc_sel;
    logic [3:0]  crc_out;
    logic [15:0] crc_val [4];

    assign word_avail = !fifo_empty_i && (pop_wait_q == 2'd0);
    assign active     = bus4_q ? 4'hF : 4'h1;
    assign word_bits  = bus4_q ? 6'd8 : 6'd32;
    assign new_word   = byte_reorder(fifo_front_data_i);
    // An exhausted word means the next bits come straight from the FIFO front.
    assign src        = (bits_left_q == 6'd0) ? new_word : shift_q;
    assign src_bits   = bus4_q ? src[31:28] : {3'b111, src[31]};
    assign crc_sel    = (state_q == CRC) ? crc_idx_q - 4'd1 : 4'd15;

    // Select the CRC bit of each active line; idle lines stay high.
    always_comb begin
        crc_out = 4'hF;
        for (int i = 0; i < 4; i++) begin
            if (active[i]) crc_out[i] = crc_val[i][crc_sel];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_crc
        sdhci_crc16 u_crc (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (crc_clr),
            .en_i   (crc_en & active[g]),
            .bit_i  (src_bits[g]),
            .crc_o  (crc_val[g])
        );
    end

    // Next-state, FIFO handshake and line values for the following bit-time.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so that no
        // path leaves one unassigned, which would infer a latch.
        state_d     = state_q;
        bus4_d      = bus4_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        bits_left_d = bits_left_q;
        crc_idx_d   = crc_idx_q;
        dat_d       = dat_q;
        oe_d        = oe_q;
        stall_d     = stall_q;
        done_d      = 1'b0;
        pop         = 1'b0;
        crc_clr     = 1'b0;
        crc_en      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    bus4_d      = bus_4bit_i;
                    byte_cnt_d  = {1'b0, block_size_i};
                    bits_left_d = '0;
                    crc_idx_d   = '0;
                    crc_clr     = 1'b1;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                if (word_avail) begin
                    pop         = 1'b1;
                    shift_d     = new_word;
                    bits_left_d = word_bits;
                    byte_cnt_d  = byte_cnt_q - WordBytes;
                    state_d     = START;
                end
            end
            START: begin
                if (sd_clk_en_i) begin
                    if (oe_q == 4'h0) begin
                        dat_d = ~active;
                        oe_d  = active;
                    end else begin
                        dat_d       = src_bits;
                        crc_en      = 1'b1;
                        shift_d     = bus4_q ? {src[27:0], 4'h0} : {src[30:0], 1'b0};
                        bits_left_d = bits_left_q - 6'd1;
                        state_d     = DATA;
                    end
                end
            end
            DATA: begin
                if (stall_q) begin
                    // Clock is gated: wait for a word, ignore stray strobes.
                    if (word_avail) begin
                        pop         = 1'b1;
                        shift_d     = new_word;
                        bits_left_d = word_bits;
                        byte_cnt_d  = byte_cnt_q - WordBytes;
                        stall_d     = 1'b0;
                    end
                end else if (sd_clk_en_i) begin
                    if (bits_left_q == 6'd0 && byte_cnt_q == '0) begin
                        dat_d     = crc_out;
                        crc_idx_d = 4'd15;
                        state_d   = CRC;
                    end else if (bits_left_q == 6'd0 && !word_avail) begin
                        stall_d = 1'b1;
                    end else begin
                        dat_d       = src_bits;
                        crc_en      = 1'b1;
                        shift_d     = bus4_q ? {src[27:0], 4'h0} : {src[30:0], 1'b0};
                        bits_left_d = ((bits_left_q == 6'd0) ? word_bits : bits_left_q) - 6'd1;
                        if (bits_left_q == 6'd0) begin
                            pop        = 1'b1;
                            byte_cnt_d = byte_cnt_q - WordBytes;
                        end
                    end
                end
            end
            CRC: begin
                if (sd_clk_en_i) begin
                    if (crc_idx_q == 4'd0) begin
                        dat_d   = 4'hF;
                        state_d = END;
                    end else begin
                        dat_d     = crc_out;
                        crc_idx_d = crc_idx_q - 4'd1;
                    end
                end
            end
            END: begin
                if (sd_clk_en_i) begin
                    dat_d   = 4'hF;
                    oe_d    = 4'h0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort_i) begin
            state_d = IDLE;
            dat_d   = 4'hF;
            oe_d    = 4'h0;
            stall_d = 1'b0;
            done_d  = 1'b0;
            pop     = 1'b0;
            crc_en  = 1'b0;
            crc_clr = 1'b0;
        end

        if (pop) begin
            pop_wait_d = 2'd2;
        end else if (pop_wait_q != 2'd0) begin
            pop_wait_d = pop_wait_q - 2'd1;
        end else begin
            pop_wait_d = pop_wait_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values computed above.
        if (!rst_ni) begin
            state_q     <= IDLE;
            bus4_q      <= 1'b0;
            byte_cnt_q  <= '0;
            shift_q     <= '0;
            bits_left_q <= '0;
            crc_idx_q   <= '0;
            dat_q       <= 4'hF;
            oe_q        <= 4'h0;
            stall_q     <= 1'b0;
            pop_wait_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus4_q      <= bus4_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            bits_left_q <= bits_left_d;
            crc_idx_q   <= crc_idx_d;
            dat_q       <= dat_d;
            oe_q        <= oe_d;
            stall_q     <= stall_d;
            pop_wait_q  <= pop_wait_d;
            done_q      <= done_d;
        end
    end

    assign fifo_pop_o = pop;
    // Drops in the very cycle the missing word is taken.
    assign clk_stop_o = stall_q & ~pop;
    assign dat_o      = dat_q;
    assign dat_oe_o   = oe_q;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;

    a_block_size: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (start_i && !abort_i && state_q == IDLE) |->
        (block_size_i != '0 && block_size_i[1:0] == 2'b00 &&
         32'(block_size_i) <= MAX_BLK_SIZE));

    a_pop_not_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        fifo_pop_o |-> !fifo_empty_i);

endmodule

// File: tb/tb_sdhci_dat_tx.sv
// Directed bench for sdhci_dat_tx with a simple FIFO responder and a
// reference model of the expected DAT stream and per-line CRC16.
module tb_sdhci_dat_tx;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        sd_clk_en_i;
    logic        start_i;
    logic        abort_i;
    logic        bus_4bit_i;
    logic [11:0] block_size_i;
    logic        fifo_empty_i;
    logic [31:0] fifo_front_data_i;
    logic        fifo_pop_o;
    logic [3:0]  dat_o;
    logic [3:0]  dat_oe_o;
    logic        clk_stop_o;
    logic        busy_o;
    logic        done_o;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    logic [31:0] mem [0:1023];
    logic [9:0]  wr_ptr = '0;
    logic [9:0]  rd_ptr = '0;

    logic [3:0]  cap  [0:4399];
    int          ncap;
    logic [3:0]  expv [0:4399];
    int          nexp;
    logic [31:0] blk_w [0:127];

    sdhci_dat_tx #(.DataWidth(32), .BlkSizeWidth(12)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .sd_clk_en_i       (sd_clk_en_i),
        .start_i           (start_i),
        .abort_i           (abort_i),
        .bus_4bit_i        (bus_4bit_i),
        .block_size_i      (block_size_i),
        .fifo_empty_i      (fifo_empty_i),
        .fifo_front_data_i (fifo_front_data_i),
        .fifo_pop_o        (fifo_pop_o),
        .dat_o             (dat_o),
        .dat_oe_o          (dat_oe_o),
        .clk_stop_o        (clk_stop_o),
        .busy_o            (busy_o),
        .done_o            (done_o)
    );

    always #5 clk = ~clk;

    assign fifo_empty_i      = (rd_ptr == wr_ptr);
    assign fifo_front_data_i = mem[rd_ptr];

    // FIFO responder: advance the read pointer on each pop.
    always @(posedge clk) begin
        if (fifo_pop_o) rd_ptr <= rd_ptr + 10'd1;
    end

    // Count done pulses away from the active edge.
    always @(negedge clk) begin
        if (done_o === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 10'd1;
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = b ^ c[15];
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // Expected line values: start bit, data, 16 CRC bits, end bit.
    task automatic build_expected(input logic b4, input int nbytes);
        logic [15:0] c [4];
        logic [31:0] w;
        logic [7:0]  byt;
        logic [3:0]  act, v, nib;
        for (int i = 0; i < 4; i++) c[i] = 16'h0000;
        act = b4 ? 4'hF : 4'h1;
        nexp = 0;
        expv[nexp] = b4 ? 4'h0 : 4'hE; nexp++;
        for (int k = 0; k < nbytes; k++) begin
            w   = blk_w[k / 4] >> (8 * (k % 4));
            byt = w[7:0];
            if (b4) begin
                for (int h = 0; h < 2; h++) begin
                    nib = (h == 0) ? byt[7:4] : byt[3:0];
                    expv[nexp] = nib; nexp++;
                    for (int i = 0; i < 4; i++) c[i] = crc_step(c[i], nib[i]);
                end
            end else begin
                for (int j = 7; j >= 0; j--) begin
                    expv[nexp] = {3'b111, byt[j]}; nexp++;
                    c[0] = crc_step(c[0], byt[j]);
                end
            end
        end
        for (int j = 15; j >= 0; j--) begin
            v = 4'hF;
            for (int i = 0; i < 4; i++) if (act[i]) v[i] = c[i][j];
            expv[nexp] = v; nexp++;
        end
        expv[nexp] = 4'hF; nexp++;
    endtask

    task automatic tick(output logic [3:0] d, output logic [3:0] oe);
        @(negedge clk); sd_clk_en_i = 1'b1;
        @(negedge clk); sd_clk_en_i = 1'b0;
        d  = dat_o;
        oe = dat_oe_o;
        repeat (2) @(negedge clk);
    endtask

    task automatic start_block(input logic b4, input logic [11:0] nbytes, input logic hold);
        @(negedge clk);
        start_i = 1'b1; bus_4bit_i = b4; block_size_i = nbytes;
        @(negedge clk);
        if (!hold) begin
            start_i = 1'b0;
        end else begin
            bus_4bit_i   = ~b4;
            block_size_i = 12'd4;
        end
        repeat (2) @(negedge clk);
        ncap = 0;
        check("pending_busy", 32'(busy_o), 32'd1);
        check("pending_oe", 32'(dat_oe_o), 32'd0);
    endtask

    // Tick until the line is released, recording every driven bit-time.
    task automatic run_ticks(input int drop_at);
        logic [3:0] d, oe;
        logic seen, fin;
        seen = 1'b0; fin = 1'b0;
        for (int t = 0; t < 4300 && !fin; t++) begin
            if (t == drop_at) start_i = 1'b0;
            tick(d, oe);
            if (oe != 4'h0) begin
                cap[ncap] = d; ncap++; seen = 1'b1;
            end else if (seen) begin
                fin = 1'b1;
            end
        end
        check("block_finished", 32'(fin), 32'd1);
        check("idle_dat", 32'(dat_o), 32'hF);
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_len"}, 32'(ncap), 32'(nexp));
        for (int i = 0; i < nexp && i < ncap; i++)
            check($sformatf("%s[%0d]", tag, i), 32'(cap[i]), 32'(expv[i]));
    endtask

    initial begin
        logic [3:0]  d, oe;
        logic [15:0] dc;

        rst_ni = 1'b0; sd_clk_en_i = 1'b0; start_i = 1'b0; abort_i = 1'b0;
        bus_4bit_i = 1'b0; block_size_i = '0;
        repeat (3) @(negedge clk);
        check("rst_dat", 32'(dat_o), 32'hF);
        check("rst_oe", 32'(dat_oe_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_pop", 32'(fifo_pop_o), 32'd0);
        check("rst_clk_stop", 32'(clk_stop_o), 32'd0);
        @(negedge clk) rst_ni = 1'b1;
        repeat (2) @(negedge clk);

        // 1-bit mode, 512 bytes of 8'hFF.
        for (int i = 0; i < 128; i++) begin
            blk_w[i] = 32'hFFFF_FFFF;
            push(32'hFFFF_FFFF);
        end
        start_block(1'b0, 12'd512, 1'b0);
        run_ticks(-1);
        build_expected(1'b0, 512);
        compare_stream("ones_1bit");
        for (int j = 0; j < 16; j++) dc[15-j] = cap[4097+j][0];
        check("crc_1bit", 32'(dc), 32'h7FA1);
        repeat (2) @(negedge clk);
        check("done_ones", 32'(done_cnt), 32'd1);
        check("busy_after_ones", 32'(busy_o), 32'd0);

        // 4-bit mode, 8 bytes, start_i held through the first bit-times.
        blk_w[0] = 32'h0302_0100; blk_w[1] = 32'h0706_0504;
        push(blk_w[0]); push(blk_w[1]);
        start_block(1'b1, 12'd8, 1'b1);
        run_ticks(5);
        build_expected(1'b1, 8);
        compare_stream("nib_4bit");
        check("nib_start", 32'(cap[0]), 32'h0);
        check("nib_b0_hi", 32'(cap[1]), 32'h0);
        check("nib_b1_lo", 32'(cap[4]), 32'h1);
        check("nib_b7_lo", 32'(cap[16]), 32'h7);
        repeat (8) @(negedge clk);
        check("done_held_start", 32'(done_cnt), 32'd2);
        check("no_restart_busy", 32'(busy_o), 32'd0);

        // 4-bit mode, 16 bytes, FIFO runs dry after the first word.
        blk_w[0] = 32'h1122_3344; blk_w[1] = 32'h5566_7788;
        blk_w[2] = 32'h99AA_BBCC; blk_w[3] = 32'hDDEE_FF00;
        build_expected(1'b1, 16);
        push(blk_w[0]);
        start_block(1'b1, 12'd16, 1'b0);
        for (int t = 0; t < 9; t++) begin
            tick(d, oe);
            cap[ncap] = d; ncap++;
        end
        tick(d, oe);
        check("stall_rise", 32'(clk_stop_o), 32'd1);
        check("stall_hold_dat", 32'(d), 32'(expv[8]));
        tick(d, oe);
        check("stall_still", 32'(clk_stop_o), 32'd1);
        check("stall_hold_dat2", 32'(d), 32'(expv[8]));
        check("stall_oe", 32'(oe), 32'hF);
        @(negedge clk);
        push(blk_w[1]); push(blk_w[2]); push(blk_w[3]);
        #1;
        check("stall_pop", 32'(fifo_pop_o), 32'd1);
        check("stall_fall", 32'(clk_stop_o), 32'd0);
        run_ticks(-1);
        compare_stream("stall_4bit");
        repeat (2) @(negedge clk);
        check("done_stall", 32'(done_cnt), 32'd3);

        // Abort in the 10th data bit-time, then a normal block.
        blk_w[0] = 32'hA5C3_0F96;
        push(blk_w[0]);
        start_block(1'b0, 12'd8, 1'b0);
        tick(d, oe);
        check("abort_start_dat", 32'(d), 32'hE);
        check("abort_start_oe", 32'(oe), 32'h1);
        for (int t = 0; t < 10; t++) tick(d, oe);
        check("abort_bit10", 32'(d), 32'hE);
        @(negedge clk) abort_i = 1'b1;
        @(negedge clk) abort_i = 1'b0;
        check("abort_oe", 32'(dat_oe_o), 32'h0);
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_dat", 32'(dat_o), 32'hF);
        check("abort_clk_stop", 32'(clk_stop_o), 32'd0);
        repeat (6) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'd3);
        blk_w[0] = 32'h89AB_CDEF; blk_w[1] = 32'h0123_4567;
        push(blk_w[0]); push(blk_w[1]);
        start_block(1'b0, 12'd8, 1'b0);
        run_ticks(-1);
        build_expected(1'b0, 8);
        compare_stream("post_abort");
        repeat (2) @(negedge clk);
        check("done_post_abort", 32'(done_cnt), 32'd4);

        // Reset dropped mid-CRC.
        push(32'hDEAD_BEEF); push(32'hCAFE_F00D);
        start_block(1'b1, 12'd8, 1'b0);
        for (int t = 0; t < 20; t++) tick(d, oe);
        check("midcrc_oe", 32'(oe), 32'hF);
        @(negedge clk);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_dat", 32'(dat_o), 32'hF);
        check("arst_oe", 32'(dat_oe_o), 32'h0);
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_clk_stop", 32'(clk_stop_o), 32'd0);
        check("arst_pop", 32'(fifo_pop_o), 32'd0);
        check("arst_done", 32'(done_o), 32'd0);
        @(negedge clk) rst_ni = 1'b1;
        repeat (4) @(negedge clk);
        check("arst_no_done", 32'(done_cnt), 32'd4);
        check("arst_idle", 32'(busy_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
